sprite_renderer: RTL and testbench
==================================

Name: sprite_renderer

Overview:
- Pixel-stage consumer of the 32x32 sprite palette-index array produced by the sprite ROM modules (bird and similar).
- Maps the VGA controller's current DrawX/DrawY onto the sprite and emits a registered palette index plus a sprite_on flag for the colour mapper.
- Holds the sprite position in frame-synchronous shadow registers so the sprite never tears mid-frame.
- Implements the hit/blink invincibility FSM.

Parameters:
- SPR_SIZE, 32: sprite edge in pixels. Fixed to match the sprite array; must be a power of two.
- BLINK_FRAMES, 64: frames of blinking after a hit.
- BLINK_PERIOD, 8: frames per hidden/visible half-period.

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  VGA vsync-derived frame signal; its rising edge marks a frame start
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- pix_valid  in  1  high when DrawX/DrawY is in the active display region
- sprite_x  in  10  requested top-left column, sampled only at frame start
- sprite_y  in  10  requested top-left row, sampled only at frame start
- facing_left  in  1  mirror request; used only with SPRITE_FLIP_EN
- hit  in  1  one-cycle pulse that starts blinking
- sprite_rgb  in  [0:31][0:31] x 10  palette-index array from the sprite ROM; index 0 is transparent
- sprite_on  out  1  the current pipelined pixel is opaque sprite
- sprite_idx  out  10  palette index for that pixel; 0 when sprite_on=0
- out_valid  out  1  pix_valid delayed to align with sprite_on/sprite_idx
- blinking  out  1  high while the FSM is in BLINK

Behaviour:
- Clock and reset: single clock Clk; Reset is synchronous and active-high.
- Reset values: all outputs are 0. pos_x, pos_y, frame_clk_d, blink counter and phase counter are 0. hide is 0. FSM state is IDLE.
- Frame tick:
  - frame_clk_d is frame_clk registered.
  - frame_tick = frame_clk & ~frame_clk_d, a one-cycle pulse.
  - On frame_tick, pos_x <= sprite_x and pos_y <= sprite_y. These are the only updates to pos_x/pos_y.
- Pipeline, latency of 2 Clk cycles from DrawX/DrawY/pix_valid to the outputs:
  - S1: dx = {1'b0,DrawX} - {1'b0,pos_x} and dy = {1'b0,DrawY} - {1'b0,pos_y}, both 11-bit.
  - S1: in_box = ~dx[10] & ~dy[10] & (dx[9:0] < 32) & (dy[9:0] < 32). The sign check means no horizontal or vertical wrap-around: a sprite partially off the right or bottom edge is clipped.
  - S1 registers: in_box, dx[4:0], dy[4:0], pix_valid.
  - S2: idx = sprite_rgb[dy][col], where col = dx, or 31-dx when flipped.
  - S2: sprite_on <= in_box & (idx != 0) & ~hide & pix_valid_s1.
  - S2: sprite_idx <= sprite_on_next ? idx : 0.
  - S2: out_valid <= pix_valid_s1.
- Blink FSM:
  - IDLE: blinking=0, hide=0. On hit -> BLINK with cnt=BLINK_FRAMES, ph=0, hide=1.
  - BLINK: blinking=1. On each frame_tick: cnt-1; ph+1 mod BLINK_PERIOD; when ph wraps to 0, hide toggles. If cnt is 1 at the tick -> IDLE, hide=0.
  - hit while in BLINK reloads cnt=BLINK_FRAMES, ph=0, hide=1. The FSM stays in BLINK.
- Simultaneous events:
  - hit and frame_tick in the same cycle: hit wins, the full reload is applied, and no decrement occurs.
  - Reset and anything else: Reset wins.
- Reset mid-operation: the FSM immediately returns to IDLE, and the pipeline flushes to zeros on the next edge.
- hide affects only sprite_on/sprite_idx. Position latching continues while hidden.

Optional Feature:
- Macro: SPRITE_FLIP_EN.
- Defined: pos_flip is latched from facing_left on frame_tick together with the position. When pos_flip=1, col = 31 - dx[4:0], giving a horizontally mirrored sprite.
- Not defined: facing_left is ignored, no flip register exists, and col = dx[4:0] always.

Test Plan:
- Reset then idle: Reset high for 2 cycles -> all outputs 0, blinking=0. After release with pix_valid=0 -> sprite_on stays 0.
- Placement: sprite_x=100, sprite_y=50, one frame_tick, then scan DrawX=100..131 on DrawY=50. Expect sprite_on/sprite_idx two cycles later, matching row 0 of the array: opaque only where the array entry is nonzero. DrawX=99 and DrawX=132 give sprite_on=0.
- Frame-synchronous position: change sprite_x from 100 to 200 mid-frame without a frame_tick -> the sprite is still drawn at 100. After the next frame_tick it is drawn at 200.
- Right-edge clip and no wrap: pos_x=1000, DrawX=5 -> sprite_on=0. pos_x=620, DrawX=639 -> in_box with dx=19.
- Blink: pulse hit, then count frame_ticks. Expect hidden for frames 0-7, visible for 8-15, and so on. blinking drops after 64 ticks. A hit at tick 30 restarts the 64-frame count. hit coincident with a tick gives no decrement.
- Flip (SPRITE_FLIP_EN defined): facing_left=1 latched at a tick, scan row 0 -> sprite_idx equals the array row 0 in reverse order. Without the macro -> forward order regardless of facing_left.

Source files
------------

// File: rtl/sprite_renderer.sv
// Sprite pixel stage: maps DrawX/DrawY onto a 32x32 palette-index sprite with a 2-cycle pipeline.
// Adds frame-synchronous position and a hit/blink FSM. Optional horizontal mirroring is enabled by SPRITE_FLIP_EN.
module sprite_renderer #(
   parameter int SPR_SIZE     = 32,
   parameter int BLINK_FRAMES = 64,
   parameter int BLINK_PERIOD = 8
) (
   input  logic                                     Clk,
   input  logic                                     Reset,
   input  logic                                     frame_clk,
   input  logic [9:0]                               DrawX,
   input  logic [9:0]                               DrawY,
   input  logic                                     pix_valid,
   input  logic [9:0]                               sprite_x,
   input  logic [9:0]                               sprite_y,
   input  logic                                     facing_left,
   input  logic                                     hit,
   input  logic [0:SPR_SIZE-1][0:SPR_SIZE-1][9:0]   sprite_rgb,
   output logic                                     sprite_on,
   output logic [9:0]                               sprite_idx,
   output logic                                     out_valid,
   output logic                                     blinking
);

   localparam int SPR_W = $clog2(SPR_SIZE);
   localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
   localparam int PH_W  = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
   localparam logic [9:0]       SPR_SIZE_V = 10'(SPR_SIZE);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLINK_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(BLINK_PERIOD - 1);

   typedef enum logic {IDLE, BLINK} state_t;

   logic             frame_clk_q;
   logic             frame_tick;
   logic [9:0]       pos_x_q, pos_y_q;
   logic [10:0]      dx, dy;
   logic             in_box;
   logic             in_box_q, pv_s1_q;
   logic [SPR_W-1:0] dx_q, dy_q, col;
   logic [9:0]       idx;
   logic             sprite_on_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PH_W-1:0]  ph_q, ph_d;
   logic             hide_q, hide_d;

   assign frame_tick = frame_clk & ~frame_clk_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_clk_q <= 1'b0;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
      end else begin
         frame_clk_q <= frame_clk;
         if (frame_tick) begin
            pos_x_q <= sprite_x;
            pos_y_q <= sprite_y;
         end
      end
   end

`ifdef SPRITE_FLIP_EN
   logic pos_flip_q;

   always_ff @(posedge Clk) begin
      if (Reset)           pos_flip_q <= 1'b0;
      else if (frame_tick) pos_flip_q <= facing_left;
   end

   // For a power-of-two edge, (SPR_SIZE-1) - dx is just the bitwise inverse.
   assign col = pos_flip_q ? ~dx_q : dx_q;
`else
   logic unused_facing;

   assign unused_facing = facing_left;
   assign col           = dx_q;
`endif

   // S1: the extra sign bit rejects pixels left of/above the sprite, so nothing wraps around.
   assign dx     = {1'b0, DrawX} - {1'b0, pos_x_q};
   assign dy     = {1'b0, DrawY} - {1'b0, pos_y_q};
   assign in_box = ~dx[10] & ~dy[10] & (dx[9:0] < SPR_SIZE_V) & (dy[9:0] < SPR_SIZE_V);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         in_box_q <= 1'b0;
         pv_s1_q  <= 1'b0;
         dx_q     <= '0;
         dy_q     <= '0;
      end else begin
         in_box_q <= in_box;
         pv_s1_q  <= pix_valid;
         dx_q     <= dx[SPR_W-1:0];
         dy_q     <= dy[SPR_W-1:0];
      end
   end

   // S2: fetch the palette index and qualify it.
   assign idx         = sprite_rgb[dy_q][col];
   assign sprite_on_d = in_box_q & (idx != 10'd0) & ~hide_q & pv_s1_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sprite_on  <= 1'b0;
         sprite_idx <= '0;
         out_valid  <= 1'b0;
      end else begin
         sprite_on  <= sprite_on_d;
         sprite_idx <= sprite_on_d ? idx : 10'd0;
         out_valid  <= pv_s1_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ph_q    <= '0;
         hide_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         hide_q  <= hide_d;
      end
   end

   // A hit always takes priority over a coincident frame tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      hide_d  = hide_q;
      case (state_q)
         IDLE: begin
            hide_d = 1'b0;
            if (hit) begin
               state_d = BLINK;
               cnt_d   = CNT_RELOAD;
               ph_d    = '0;
               hide_d  = 1'b1;
            end
         end
         BLINK: begin
            if (hit) begin
               cnt_d  = CNT_RELOAD;
               ph_d   = '0;
               hide_d = 1'b1;
            end else if (frame_tick) begin
               cnt_d = cnt_q - CNT_ONE;
               if (ph_q == PH_LAST) begin
                  ph_d   = '0;
                  hide_d = ~hide_q;
               end else begin
                  ph_d = ph_q + PH_W'(1);
               end
               if (cnt_q == CNT_ONE) begin
                  state_d = IDLE;
                  hide_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      blinking = (state_q == BLINK);
   end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed, table-driven bench for sprite_renderer: placement, clipping, frame sync, blink FSM and optional flip.
// Compile with +define+SPRITE_FLIP_EN to expect mirrored output when facing_left is latched.
module tb_sprite_renderer;

   logic                           Clk = 1'b0;
   logic                           Reset;
   logic                           frame_clk;
   logic [9:0]                     DrawX, DrawY;
   logic                           pix_valid;
   logic [9:0]                     sprite_x, sprite_y;
   logic                           facing_left;
   logic                           hit;
   logic [0:31][0:31][9:0]         sprite_rgb;
   logic                           sprite_on;
   logic [9:0]                     sprite_idx;
   logic                           out_valid;
   logic                           blinking;

   int n_vec = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   sprite_renderer dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
      .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .facing_left(facing_left),
      .hit(hit), .sprite_rgb(sprite_rgb),
      .sprite_on(sprite_on), .sprite_idx(sprite_idx),
      .out_valid(out_valid), .blinking(blinking)
   );

   // Sprite content: transparent on every fourth diagonal, otherwise a unique nonzero index.
   function automatic logic [9:0] spr(input int r, input int c);
      if (((r + c) % 4) == 0) return 10'd0;
      return 10'(((r * 32 + c) % 1000) + 1);
   endfunction

   typedef struct {
      string      name;
      logic [9:0] sx, sy;
      logic       tk;
      logic [9:0] x, y;
      logic       pv;
      logic       eon;
      logic [9:0] eidx;
      logic       eov;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clk); frame_clk = 1'b1;
      @(negedge Clk); frame_clk = 1'b0;
   endtask

   task automatic pulse_hit();
      @(negedge Clk); hit = 1'b1;
      @(negedge Clk); hit = 1'b0;
   endtask

   // Drive one pixel, then sample once it has passed through both stages.
   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic pv);
      @(negedge Clk);
      DrawX = x; DrawY = y; pix_valid = pv;
      @(negedge Clk);
      @(negedge Clk);
   endtask

   task automatic chk_pix(input string name, input logic [9:0] x, input logic [9:0] y,
                          input logic eon, input logic [9:0] eidx);
      pix(x, y, 1'b1);
      check({name, ".on"}, 10'(sprite_on), 10'(eon));
      check({name, ".idx"}, sprite_idx, eidx);
   endtask

   // Ticks counted from the last hit; hidden during even 8-frame half-periods until 64 ticks elapse.
   task automatic blink_check(input int n);
      logic vis, bl;
      bl  = (n < 64);
      vis = !bl || (((n / 8) % 2) == 1);
      check($sformatf("blink%0d.blinking", n), 10'(blinking), 10'(bl));
      chk_pix($sformatf("blink%0d.pix", n), 10'd101, 10'd50, vis, vis ? spr(0, 1) : 10'd0);
   endtask

   task automatic run_ticks(input int from, input int to);
      for (int n = from; n <= to; n++) begin
         tick();
         blink_check(n);
      end
   endtask

   // Streams DrawX = 98..133 on row 50 back-to-back; sprite assumed at (100,50).
   task automatic scan(input string name, input bit mirrored);
      for (int k = 0; k < 38; k++) begin
         @(negedge Clk);
         if (k >= 2) begin
            int col;
            logic eon;
            logic [9:0] eidx;
            col  = k - 2 - 2;
            eidx = 10'd0;
            if (col >= 0 && col < 32) eidx = spr(0, mirrored ? 31 - col : col);
            eon = (eidx != 10'd0);
            check($sformatf("%s.x%0d.on", name, 98 + k - 2), 10'(sprite_on), 10'(eon));
            check($sformatf("%s.x%0d.idx", name, 98 + k - 2), sprite_idx, eidx);
         end
         if (k < 36) begin
            DrawX = 10'(98 + k); DrawY = 10'd50; pix_valid = 1'b1;
         end else begin
            pix_valid = 1'b0;
         end
      end
   endtask

   initial begin
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            sprite_rgb[r][c] = spr(r, c);

      Reset = 1'b1; frame_clk = 1'b0; DrawX = 10'd101; DrawY = 10'd50; pix_valid = 1'b1;
      sprite_x = 10'd100; sprite_y = 10'd50; facing_left = 1'b0; hit = 1'b1;

      // Reset held with busy inputs: everything stays zero.
      @(negedge Clk); @(negedge Clk);
      check("rst.sprite_on", 10'(sprite_on), 10'd0);
      check("rst.sprite_idx", sprite_idx, 10'd0);
      check("rst.out_valid", 10'(out_valid), 10'd0);
      check("rst.blinking", 10'(blinking), 10'd0);
      Reset = 1'b0; hit = 1'b0; pix_valid = 1'b0;
      repeat (3) @(negedge Clk);
      check("idle.sprite_on", 10'(sprite_on), 10'd0);
      check("idle.out_valid", 10'(out_valid), 10'd0);
      check("idle.blinking", 10'(blinking), 10'd0);

      tbl[0]  = '{"origin_transp", 10'd100, 10'd50,  1'b1, 10'd100, 10'd50, 1'b1, 1'b0, 10'd0,     1'b1};
      tbl[1]  = '{"col1",          10'd100, 10'd50,  1'b0, 10'd101, 10'd50, 1'b1, 1'b1, spr(0, 1),  1'b1};
      tbl[2]  = '{"left_of",       10'd100, 10'd50,  1'b0, 10'd99,  10'd50, 1'b1, 1'b0, 10'd0,     1'b1};
      tbl[3]  = '{"right_of",      10'd100, 10'd50,  1'b0, 10'd132, 10'd50, 1'b1, 1'b0, 10'd0,     1'b1};
      tbl[4]  = '{"last_col",      10'd100, 10'd50,  1'b0, 10'd131, 10'd50, 1'b1, 1'b1, spr(0, 31), 1'b1};
      tbl[5]  = '{"last_row",      10'd100, 10'd50,  1'b0, 10'd102, 10'd81, 1'b1, 1'b1, spr(31, 2), 1'b1};
      tbl[6]  = '{"above",         10'd100, 10'd50,  1'b0, 10'd102, 10'd49, 1'b1, 1'b0, 10'd0,     1'b1};
      tbl[7]  = '{"below",         10'd100, 10'd50,  1'b0, 10'd102, 10'd82, 1'b1, 1'b0, 10'd0,     1'b1};
      tbl[8]  = '{"not_valid",     10'd100, 10'd50,  1'b0, 10'd101, 10'd50, 1'b0, 1'b0, 10'd0,     1'b0};
      tbl[9]  = '{"no_wrap",       10'd1000, 10'd50, 1'b1, 10'd5,   10'd50, 1'b1, 1'b0, 10'd0,     1'b1};
      tbl[10] = '{"clip_dx19",     10'd620, 10'd50,  1'b1, 10'd639, 10'd50, 1'b1, 1'b1, spr(0, 19), 1'b1};
      tbl[11] = '{"clip_left",     10'd620, 10'd50,  1'b0, 10'd619, 10'd50, 1'b1, 1'b0, 10'd0,     1'b1};

      for (int i = 0; i < 12; i++) begin
         sprite_x = tbl[i].sx; sprite_y = tbl[i].sy;
         if (tbl[i].tk) tick();
         pix(tbl[i].x, tbl[i].y, tbl[i].pv);
         check({tbl[i].name, ".on"}, 10'(sprite_on), 10'(tbl[i].eon));
         check({tbl[i].name, ".idx"}, sprite_idx, tbl[i].eidx);
         check({tbl[i].name, ".valid"}, 10'(out_valid), 10'(tbl[i].eov));
         $display("vector %0d %s: x=%0d y=%0d on=%0b idx=%0d", i, tbl[i].name,
                  tbl[i].x, tbl[i].y, sprite_on, sprite_idx);
      end

      // Back-to-back stream exercises the 2-cycle latency.
      sprite_x = 10'd100; sprite_y = 10'd50;
      tick();
      scan("scan", 1'b0);

      // Position requests take effect only at a frame tick.
      sprite_x = 10'd200;
      chk_pix("sync.old_pos", 10'd101, 10'd50, 1'b1, spr(0, 1));
      chk_pix("sync.new_pos_early", 10'd201, 10'd50, 1'b0, 10'd0);
      tick();
      chk_pix("sync.new_pos", 10'd201, 10'd50, 1'b1, spr(0, 1));
      chk_pix("sync.old_pos_gone", 10'd101, 10'd50, 1'b0, 10'd0);
      sprite_x = 10'd100;
      tick();

      // Blink: full 64-frame run.
      pulse_hit();
      blink_check(0);
      run_ticks(1, 64);

      // Re-hit at tick 30 restarts the count.
      pulse_hit();
      run_ticks(1, 30);
      pulse_hit();
      blink_check(0);
      run_ticks(1, 64);

      // Hit coincident with a tick: reload without decrement.
      pulse_hit();
      run_ticks(1, 5);
      @(negedge Clk); frame_clk = 1'b1; hit = 1'b1;
      @(negedge Clk); frame_clk = 1'b0; hit = 1'b0;
      blink_check(0);
      run_ticks(1, 64);

      // Reset mid-blink returns to idle and flushes the pipeline.
      pulse_hit();
      run_ticks(1, 3);
      @(negedge Clk); DrawX = 10'd101; DrawY = 10'd50; pix_valid = 1'b1; Reset = 1'b1;
      @(negedge Clk); Reset = 1'b0;
      check("midrst.blinking", 10'(blinking), 10'd0);
      check("midrst.sprite_on", 10'(sprite_on), 10'd0);
      check("midrst.out_valid", 10'(out_valid), 10'd0);
      sprite_x = 10'd100; sprite_y = 10'd50;
      tick();
      chk_pix("midrst.visible", 10'd101, 10'd50, 1'b1, spr(0, 1));

      // Mirroring request latched at a tick.
      facing_left = 1'b1;
      tick();
`ifdef SPRITE_FLIP_EN
      scan("flip", 1'b1);
`else
      scan("noflip", 1'b0);
`endif
      facing_left = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
